// File: rtl/ex_mem_ctrl.sv
// rtl/ex_mem_ctrl.sv - EX/MEM pipeline register with stall hold, bubble insertion, flush and multi-cycle feedback
module ex_mem_ctrl #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int CNT_W      = 2,
    parameter int PERF_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_ex,
    input  logic                  stall_mem,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_wreg,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_reg2,
    input  logic [2*DATA_W-1:0]   hilo_temp_i,
    input  logic [CNT_W-1:0]      cnt_i,
    output logic                  mem_valid,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_wreg,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_mem_addr,
    output logic [DATA_W-1:0]     mem_reg2,
    output logic [2*DATA_W-1:0]   hilo_temp_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic [PERF_W-1:0]     bubble_cnt
);

    // Decoded stage-boundary action; priority rst > flush > hold > bubble > advance.
    logic do_clear;
    logic do_hold;
    logic do_bubble;

    // Combinational action decode shared by all register groups.
    always_comb begin
        do_clear  = 1'b0;
        do_hold   = 1'b0;
        do_bubble = 1'b0;
        if (rst || flush) begin
            do_clear = 1'b1;
        end else if (stall_mem) begin
            do_hold = 1'b1;
        end else if (stall_ex) begin
            do_bubble = 1'b1;
        end
    end

    // MEM-side payload: cleared on reset/flush/bubble, frozen on hold, copied on advance.
    always_ff @(posedge clk) begin
        if (do_clear || do_bubble) begin
            mem_valid    <= 1'b0;
            mem_wd       <= '0;
            mem_wdata    <= '0;
            mem_wreg     <= 1'b0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
        end else if (!do_hold) begin
            mem_valid    <= ex_valid;
            mem_wd       <= ex_wd;
            mem_wdata    <= ex_wdata;
            mem_wreg     <= ex_wreg;
            mem_whilo    <= ex_whilo;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
        end
    end

    // Multi-cycle feedback: captured on a bubble so EX sees its partial result next cycle,
    // kept across a hold, and dropped once the instruction advances or is discarded.
    always_ff @(posedge clk) begin
        if (do_clear) begin
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end else if (do_bubble) begin
            hilo_temp_o <= hilo_temp_i;
            cnt_o       <= cnt_i;
        end else if (!do_hold) begin
            hilo_temp_o <= '0;
            cnt_o       <= '0;
        end
    end

    // Saturating bubble counter; only reset clears it, flushes are not bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (do_bubble && (bubble_cnt != {PERF_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_mem_ctrl.sv
// tb/tb_ex_mem_ctrl.sv - scoreboard bench for ex_mem_ctrl with directed vectors
module tb_ex_mem_ctrl;

    typedef struct {
        logic        valid;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        wreg;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [15:0] bub;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall_ex, stall_mem, flush;
    vec_t        in;
    logic        mem_valid, mem_wreg, mem_whilo;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
    logic [15:0] bubble_cnt;

    logic        s_valid, s_wreg, s_whilo;
    logic [4:0]  s_wd;
    logic [31:0] s_wdata, s_hi, s_lo, s_addr, s_reg2;
    logic [7:0]  s_aluop;
    logic [63:0] s_hilo;
    logic [1:0]  s_cnt;
    logic [3:0]  s_bubble;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] bub = 0;

    always #5 clk = ~clk;

    ex_mem_ctrl dut (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_valid(in.valid), .ex_wd(in.wd), .ex_wdata(in.wdata), .ex_wreg(in.wreg),
        .ex_whilo(in.whilo), .ex_hi(in.hi), .ex_lo(in.lo), .ex_aluop(in.aluop),
        .ex_mem_addr(in.addr), .ex_reg2(in.reg2), .hilo_temp_i(in.hilo), .cnt_i(in.cnt),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_temp_o(hilo_temp_o),
        .cnt_o(cnt_o), .bubble_cnt(bubble_cnt)
    );

    ex_mem_ctrl #(.PERF_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_valid(in.valid), .ex_wd(in.wd), .ex_wdata(in.wdata), .ex_wreg(in.wreg),
        .ex_whilo(in.whilo), .ex_hi(in.hi), .ex_lo(in.lo), .ex_aluop(in.aluop),
        .ex_mem_addr(in.addr), .ex_reg2(in.reg2), .hilo_temp_i(in.hilo), .cnt_i(in.cnt),
        .mem_valid(s_valid), .mem_wd(s_wd), .mem_wdata(s_wdata), .mem_wreg(s_wreg),
        .mem_whilo(s_whilo), .mem_hi(s_hi), .mem_lo(s_lo), .mem_aluop(s_aluop),
        .mem_mem_addr(s_addr), .mem_reg2(s_reg2), .hilo_temp_o(s_hilo),
        .cnt_o(s_cnt), .bubble_cnt(s_bubble)
    );

    task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s actual=%h expected=%h", tag, name, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a new registered state, compare it against the oldest expectation.
    initial begin
        exp_t e;
        logic [3:0] sat;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk(e.tag, "mem_valid", 64'(mem_valid), 64'(e.v.valid));
                chk(e.tag, "mem_wd",    64'(mem_wd),    64'(e.v.wd));
                chk(e.tag, "mem_wdata", 64'(mem_wdata), 64'(e.v.wdata));
                chk(e.tag, "mem_wreg",  64'(mem_wreg),  64'(e.v.wreg));
                chk(e.tag, "mem_whilo", 64'(mem_whilo), 64'(e.v.whilo));
                chk(e.tag, "mem_hi",    64'(mem_hi),    64'(e.v.hi));
                chk(e.tag, "mem_lo",    64'(mem_lo),    64'(e.v.lo));
                chk(e.tag, "mem_aluop", 64'(mem_aluop), 64'(e.v.aluop));
                chk(e.tag, "mem_addr",  64'(mem_mem_addr), 64'(e.v.addr));
                chk(e.tag, "mem_reg2",  64'(mem_reg2),  64'(e.v.reg2));
                chk(e.tag, "hilo_temp_o", hilo_temp_o,  e.v.hilo);
                chk(e.tag, "cnt_o",     64'(cnt_o),     64'(e.v.cnt));
                chk(e.tag, "bubble_cnt", 64'(bubble_cnt), 64'(e.bub));
                sat = (e.bub > 16'd15) ? 4'hF : e.bub[3:0];
                chk(e.tag, "bubble_cnt_sat", 64'(s_bubble), 64'(sat));
                chk(e.tag, "sat_cnt_o", 64'(s_cnt), 64'(e.v.cnt));
            end
        end
    end

    function automatic vec_t zero_vec(input logic [63:0] hilo, input logic [1:0] cnt);
        vec_t z;
        z = '{default: '0};
        z.hilo = hilo;
        z.cnt  = cnt;
        return z;
    endfunction

    function automatic vec_t passed(input vec_t v);
        vec_t p;
        p = v;
        p.hilo = '0;
        p.cnt  = '0;
        return p;
    endfunction

    // Apply one cycle of stimulus at the falling edge and queue the state expected after the next rising edge.
    task automatic step(input string tag, input vec_t v, input logic r, input logic fl,
                        input logic sm, input logic se, input vec_t exp_v, input logic [15:0] exp_bub);
        exp_t e;
        @(negedge clk);
        in = v; rst = r; flush = fl; stall_mem = sm; stall_ex = se;
        e.v = exp_v; e.bub = exp_bub; e.tag = tag;
        sb.push_back(e);
    endtask

    vec_t va, vb, vc, vbusy, held;

    initial begin
        rst = 1'b1; flush = 1'b0; stall_mem = 1'b0; stall_ex = 1'b0;
        vbusy = '{valid: 1'b1, wd: 5'h0A, wdata: 32'hA5A5A5A5, wreg: 1'b1, whilo: 1'b1,
                  hi: 32'h11111111, lo: 32'h22222222, aluop: 8'h24, addr: 32'h80001000,
                  reg2: 32'h33333333, hilo: 64'hFFFF_0000_FFFF_0000, cnt: 2'd3};
        va = '{valid: 1'b1, wd: 5'h1F, wdata: 32'hDEADBEEF, wreg: 1'b1, whilo: 1'b0,
               hi: 32'h0, lo: 32'h0, aluop: 8'h21, addr: 32'h0000_0040,
               reg2: 32'hCAFEF00D, hilo: 64'h1234_5678_9ABC_DEF0, cnt: 2'd3};
        vb = '{valid: 1'b1, wd: 5'h03, wdata: 32'h00000007, wreg: 1'b0, whilo: 1'b1,
               hi: 32'hAAAA0001, lo: 32'h5555FFFE, aluop: 8'h18, addr: 32'h0,
               reg2: 32'h0, hilo: 64'h0000_0001_FFFF_FFFE, cnt: 2'd1};
        vc = '{valid: 1'b1, wd: 5'h08, wdata: 32'h12345678, wreg: 1'b1, whilo: 1'b0,
               hi: 32'h0, lo: 32'h0, aluop: 8'h2B, addr: 32'h0000_0100,
               reg2: 32'h87654321, hilo: 64'h0, cnt: 2'd0};

        // reset for two cycles with busy inputs
        step("reset0", vbusy, 1, 0, 0, 0, zero_vec(64'h0, 2'd0), 16'd0);
        step("reset1", vbusy, 1, 0, 1, 1, zero_vec(64'h0, 2'd0), 16'd0);

        // plain advance
        step("advance", va, 0, 0, 0, 0, passed(va), 16'd0);

        // two bubbles capture feedback, then release
        step("bubble1", vb, 0, 0, 0, 1, zero_vec(64'h0000_0001_FFFF_FFFE, 2'd1), 16'd1);
        step("bubble2", vb, 0, 0, 0, 1, zero_vec(64'h0000_0001_FFFF_FFFE, 2'd1), 16'd2);
        step("release", vb, 0, 0, 0, 0, passed(vb), 16'd2);

        // load then hold for three cycles while EX data changes
        step("load", vc, 0, 0, 0, 0, passed(vc), 16'd2);
        held = va;
        for (int i = 0; i < 3; i++) begin
            held.wdata = 32'hF000_0000 + 32'(i);
            step("hold", held, 0, 0, 1, 1, passed(vc), 16'd2);
        end

        // feedback survives a hold, then flush beats the hold
        held = vb; held.hilo = 64'h0000_0002_0000_0003; held.cnt = 2'd2;
        step("bubble_cnt2", held, 0, 0, 0, 1, zero_vec(64'h0000_0002_0000_0003, 2'd2), 16'd3);
        held.hilo = 64'hDEAD_0000_0000_BEEF; held.cnt = 2'd3;
        step("hold_fb", held, 0, 0, 1, 1, zero_vec(64'h0000_0002_0000_0003, 2'd2), 16'd3);
        step("flush", va, 0, 1, 1, 1, zero_vec(64'h0, 2'd0), 16'd3);
        step("after_flush", vc, 0, 0, 0, 0, passed(vc), 16'd3);

        // 21 bubbles: wide counter reaches 24, 4-bit counter pins at 15
        bub = 16'd3;
        for (int i = 0; i < 21; i++) begin
            bub = bub + 16'd1;
            step("sat", vb, 0, 0, 0, 1, zero_vec(64'h0000_0001_FFFF_FFFE, 2'd1), bub);
        end

        // reset mid-stall wins, then advance resumes
        step("reset_stall", vbusy, 1, 0, 0, 1, zero_vec(64'h0, 2'd0), 16'd0);
        step("post_reset", va, 0, 0, 0, 0, passed(va), 16'd0);

        begin
            int budget;
            budget = 10;
            while (sb.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            @(negedge clk);
            if (sb.size() != 0) begin
                errors++;
                checks++;
                $display("FAIL drain actual=%0d pending expected=0", sb.size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
